// File: rtl/cavlc_run_scanner.sv
// One-pass CAVLC coefficient scanner: TotalCoeff, TrailingOnes/signs, total_zeros and run_before per block.
// Optional level capture output enabled by defining CAVLC_LEVEL_CAPTURE_EN.
module cavlc_run_scanner #(
  parameter int COEFF_W   = 8,
  parameter int MAX_COEFF = 16,
  parameter int CNT_W     = $clog2(MAX_COEFF + 1)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               clear,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [COEFF_W-1:0]                 in_coeff,
  input  logic                               in_last,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [CNT_W-1:0]                   total_coeff,
  output logic [1:0]                         trailing_ones,
  output logic [2:0]                         t1_signs,
  output logic [CNT_W-1:0]                   total_zeros,
  output logic [MAX_COEFF-1:0][CNT_W-1:0]    run_before,
`ifdef CAVLC_LEVEL_CAPTURE_EN
  output logic [MAX_COEFF-1:0][COEFF_W-1:0]  level_list,
`endif
  output logic                               err_len
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_e;

  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_COEFF);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_COEFF - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v >= MAX_CNT) ? v : v + 1'b1;
  endfunction

  state_e                            state_q, state_d;
  logic [CNT_W-1:0]                  beat_q, beat_d;
  logic [CNT_W-1:0]                  tc_q, tc_d;
  logic [CNT_W-1:0]                  tz_q, tz_d;
  logic [1:0]                        t1_q, t1_d;
  logic [2:0]                        t1_sign_q, t1_sign_d;
  logic                              t1_closed_q, t1_closed_d;
  logic                              err_q, err_d;
  logic [MAX_COEFF-1:0][CNT_W-1:0]   run_q, run_d;
`ifdef CAVLC_LEVEL_CAPTURE_EN
  logic [MAX_COEFF-1:0][COEFF_W-1:0] level_q, level_d;
`endif

  logic accept, is_zero, is_one, zero_res;

  assign in_ready = (state_q != DONE) & ~clear;
  assign accept   = in_valid & in_ready;
  assign is_zero  = (in_coeff == '0);
  assign is_one   = (in_coeff == COEFF_W'(1)) || (in_coeff == '1);

  // NOTE: every _d gets its default first so this block can never infer a latch.
  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    tc_d        = tc_q;
    tz_d        = tz_q;
    t1_d        = t1_q;
    t1_sign_d   = t1_sign_q;
    t1_closed_d = t1_closed_q;
    err_d       = err_q;
    run_d       = run_q;
`ifdef CAVLC_LEVEL_CAPTURE_EN
    level_d     = level_q;
`endif
    zero_res    = 1'b0;

    if (accept) begin
      beat_d = sat_inc(beat_q);
      if (!is_zero) begin
        tc_d = sat_inc(tc_q);
`ifdef CAVLC_LEVEL_CAPTURE_EN
        for (int i = 0; i < MAX_COEFF; i++)
          if (tc_q == CNT_W'(i)) level_d[i] = in_coeff;
`endif
        if (!t1_closed_q) begin
          if (!is_one) begin
            t1_closed_d = 1'b1;
          end else if (t1_q != 2'd3) begin
            t1_sign_d[t1_q] = in_coeff[COEFF_W-1];
            t1_d            = t1_q + 2'd1;
          end
        end
      end else if (tc_q != '0) begin
        // Zeros extend the run of the most recent non-zero; leading zeros are ignored.
        tz_d = sat_inc(tz_q);
        for (int i = 0; i < MAX_COEFF; i++)
          if (tc_q == CNT_W'(i + 1)) run_d[i] = sat_inc(run_q[i]);
      end
      if (in_last || beat_q == LAST_BEAT) begin
        state_d = DONE;
        err_d   = ~in_last;
      end else begin
        state_d = SCAN;
      end
    end

    if (state_q == DONE && out_ready) begin
      state_d  = IDLE;
      zero_res = 1'b1;
    end

    if (clear) begin
      state_d  = IDLE;
      zero_res = 1'b1;
    end

    if (zero_res) begin
      beat_d      = '0;
      tc_d        = '0;
      tz_d        = '0;
      t1_d        = '0;
      t1_sign_d   = '0;
      t1_closed_d = 1'b0;
      err_d       = 1'b0;
      run_d       = '0;
`ifdef CAVLC_LEVEL_CAPTURE_EN
      level_d     = '0;
`endif
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; result lists are reset since they are read as outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      beat_q      <= '0;
      tc_q        <= '0;
      tz_q        <= '0;
      t1_q        <= '0;
      t1_sign_q   <= '0;
      t1_closed_q <= 1'b0;
      err_q       <= 1'b0;
      run_q       <= '0;
`ifdef CAVLC_LEVEL_CAPTURE_EN
      level_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      tc_q        <= tc_d;
      tz_q        <= tz_d;
      t1_q        <= t1_d;
      t1_sign_q   <= t1_sign_d;
      t1_closed_q <= t1_closed_d;
      err_q       <= err_d;
      run_q       <= run_d;
`ifdef CAVLC_LEVEL_CAPTURE_EN
      level_q     <= level_d;
`endif
    end
  end

  assign out_valid     = (state_q == DONE);
  assign total_coeff   = tc_q;
  assign trailing_ones = t1_q;
  assign t1_signs      = t1_sign_q;
  assign total_zeros   = tz_q;
  assign run_before    = run_q;
  assign err_len       = err_q;
`ifdef CAVLC_LEVEL_CAPTURE_EN
  assign level_list    = level_q;
`endif

endmodule

// File: doc/cavlc_run_scanner.md
Name: cavlc_run_scanner

Overview:
- Parametrised successor to the CAVLC run-before counter; one-pass coefficient scanner feeding the CAVLC table/bitstream packer.
- Consumes one quantised coefficient per accepted beat, in reverse zig-zag order (highest frequency first), with a valid/ready handshake.
- Per block, produces TotalCoeff, TrailingOnes with their signs, total_zeros and a per-coefficient run_before list, then holds them until the packer acknowledges.
- Handles luma 4x4 (16), AC (15) and chroma DC (4/8) blocks through in_last and MAX_COEFF.

Parameters:
COEFF_W, 8, coefficient width, two's complement
MAX_COEFF, 16, maximum coefficients per block; list depth
CNT_W, $clog2(MAX_COEFF+1), width of all counts

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-low
clear  input  1  synchronous abort; returns to IDLE and zeroes all results
in_valid  input  1  coefficient beat valid
in_ready  output  1  scanner can accept a beat
in_coeff  input  COEFF_W  coefficient, reverse scan order
in_last  input  1  final beat of block
out_valid  output  1  results valid and stable
out_ready  input  1  packer consumes results
total_coeff  output  CNT_W  count of non-zero coefficients
trailing_ones  output  2  0..3
t1_signs  output  3  bit k = 1 if trailing one k is negative; k=0 is the first received
total_zeros  output  CNT_W  zeros received after the first non-zero
run_before  output  CNT_W x MAX_COEFF  entry i is the zero run after non-zero i (i=0 is the first received)
err_len  output  1  block reached MAX_COEFF beats without in_last

Behaviour:
- Reset (rst=0, async): state IDLE, in_ready=1, out_valid=0, all counts, lists, signs and err_len = 0.
- Beat accepted when in_valid & in_ready.
- FSM:
  - IDLE→SCAN on the first accepted beat, which is also processed.
  - SCAN→DONE on an accepted beat with in_last=1, or on the MAX_COEFF-th beat. In the forced case err_len=1.
  - DONE→IDLE on out_ready.
- in_ready = (state != DONE) & !clear. out_valid = (state == DONE).
- Latency: out_valid rises the cycle after the last beat is accepted.
- Next block can be accepted the cycle after the out_ready handshake.
- Per accepted non-zero beat, with nz = running non-zero count:
  - total_coeff increments.
  - zero_run resets to 0.
  - The previous non-zero's entry, run_before[nz-1], is finalised when nz>0.
- Per accepted zero beat: when seen_nz=1, zero_run increments and total_zeros increments.
- Zeros before the first non-zero are ignored.
- The last non-zero's run_before entry holds the trailing zero run at block end; the packer discards it.
- Trailing ones:
  - While t1_open=1 (set at block start) and the non-zero equals ±1 and trailing_ones<3: trailing_ones increments and the sign is written to t1_signs[trailing_ones].
  - The first non-zero with |coeff| != 1 clears t1_open.
- Arithmetic: all counters saturate at MAX_COEFF and cannot wrap. Comparisons are on the full COEFF_W signed value.
- All-zero block: total_coeff=0, trailing_ones=0, total_zeros=0, all lists 0.
- clear has priority over a simultaneous beat: the beat is dropped.
- clear during DONE drops the results without out_ready; out_valid falls the next cycle.
- Outputs are stable while out_valid=1 and out_ready=0.
- Unused run_before entries (index ≥ total_coeff) read 0.
- Results are zeroed on entry to IDLE.

Optional Feature:
- Macro CAVLC_LEVEL_CAPTURE_EN.
- When defined: adds output level_list (COEFF_W x MAX_COEFF), which stores each non-zero coefficient at index nz in arrival order; trailing ones are included. Reset and clear zero it.
- When undefined: no level storage or port; the level path is fed separately.

Test Plan:
- Block 0,0,0,0,0,0,0,1,0,1,-1,0,0,-1,3,0 with in_last on the 16th beat → total_coeff=5, trailing_ones=3, t1_signs=3'b100, total_zeros=4, run_before=[1,0,2,0,1,0...], err_len=0, out_valid on cycle 17.
- 16 zeros, in_last on the 16th beat → all counts 0, out_valid=1, err_len=0.
- Chroma DC 4 beats 2,-1,1,0 with in_last on beat 4 → total_coeff=3, trailing_ones=0, total_zeros=1, run_before=[0,0,1].
- 16 beats with no in_last → forced DONE, err_len=1. Hold out_ready=0 for 5 cycles: outputs stable, in_ready=0.
- clear asserted on beat 6 of 16 together with in_valid → beat dropped, IDLE next cycle, counts 0. A new block then scans correctly.
- Async reset asserted mid-SCAN between clock edges → outputs 0 immediately. Reset deasserted, then back-to-back blocks with out_ready tied high → out_valid pulses one cycle per block.
